// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID reader: FSM states, word addresses
// and the default per-read timeout.
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        FINISH
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/sysid_reader.sv
// Reads the ID word then the timestamp word over a small Avalon-MM read port and
// compares the ID against EXPECTED_ID. Define SYSID_READER_TIMEOUT_EN to add a per-read abort counter.
module sysid_reader
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        timeout
);

    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_lat_cnt;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic        r_id_match;

    logic w_in_rd;
    logic w_in_lat;
    logic w_id_phase;
    logic w_accept;
    logic w_capture;
    logic w_timeout_hit;
    logic w_enter_finish;

    assign w_in_rd        = (r_state == RD_ID) || (r_state == RD_TS);
    assign w_in_lat       = (r_state == LAT_ID) || (r_state == LAT_TS);
    assign w_id_phase     = (r_state == RD_ID) || (r_state == LAT_ID);
    assign w_accept       = w_in_rd && !avm_waitrequest;
    // Zero latency captures in the accept cycle; otherwise on the last latency cycle.
    assign w_capture      = (LAT == 2'd0) ? w_accept : (w_in_lat && (r_lat_cnt == LAT));
    assign w_enter_finish = (w_next_state == FINISH) && (r_state != FINISH);

`ifdef SYSID_READER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    assign w_timeout_hit = (w_in_rd || w_in_lat) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES)) && !w_capture;

    // Counts cycles spent on the current read, starting at 1 on entry to a read state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((w_next_state == RD_ID && r_state != RD_ID) ||
                (w_next_state == RD_TS && r_state != RD_TS))
                r_to_cnt <= TO_W'(1);
            else if (w_in_rd || w_in_lat)
                r_to_cnt <= r_to_cnt + TO_W'(1);

            if (r_state == IDLE && start)
                r_timeout <= 1'b0;
            else if (w_timeout_hit)
                r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout_hit        = 1'b0;
    assign timeout              = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assignment ahead of the case keeps every path driven, so no latch.
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next_state = RD_ID;
            RD_ID: begin
                if (w_timeout_hit)  w_next_state = FINISH;
                else if (w_accept)  w_next_state = (LAT == 2'd0) ? RD_TS : LAT_ID;
            end
            LAT_ID: begin
                if (w_timeout_hit)  w_next_state = FINISH;
                else if (w_capture) w_next_state = RD_TS;
            end
            RD_TS: begin
                if (w_timeout_hit)  w_next_state = FINISH;
                else if (w_accept)  w_next_state = (LAT == 2'd0) ? FINISH : LAT_TS;
            end
            LAT_TS: begin
                if (w_timeout_hit)  w_next_state = FINISH;
                else if (w_capture) w_next_state = FINISH;
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != IDLE);
        done        = (r_state == FINISH);
        avm_read    = w_in_rd;
        avm_address = ((r_state == RD_TS) || (r_state == LAT_TS)) ? ADDR_TS : ADDR_ID;
    end

    // NOTE: captured words are plain registers, so the synchronous reset clears them too.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lat_cnt  <= 2'd0;
            r_id_value <= '0;
            r_ts_value <= '0;
            r_id_match <= 1'b0;
        end else begin
            if (w_accept)      r_lat_cnt <= 2'd1;
            else if (w_in_lat) r_lat_cnt <= r_lat_cnt + 2'd1;

            if (w_capture) begin
                if (w_id_phase) r_id_value <= avm_readdata;
                else            r_ts_value <= avm_readdata;
            end

            if (r_state == IDLE && start)
                r_id_match <= 1'b0;
            else if (w_enter_finish)
                r_id_match <= !w_timeout_hit && (r_id_value == EXPECTED_ID);
        end
    end

    assign id_value        = r_id_value;
    assign timestamp_value = r_ts_value;
    assign id_match        = r_id_match;

endmodule

// File: tb/tb_sysid_reader.sv
// Bench for sysid_reader: a zero-latency and a two-cycle-latency instance driven by
// a behavioural responder, checked against a cycle-trace model of each sequence.
module tb_sysid_reader;

    localparam logic [31:0] EXP_ID = 32'h1234_5678;
    localparam int          TO_CYC = 16;
`ifdef SYSID_READER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        rd    [2];
    logic        addr  [2];
    logic        wr    [2];
    logic        busy  [2];
    logic        done  [2];
    logic        match [2];
    logic        tmo   [2];
    logic [31:0] rdata [2];
    logic [31:0] idv   [2];
    logic [31:0] tsv   [2];

    always #5 clock = ~clock;

    sysid_reader #(.EXPECTED_ID(EXP_ID), .READ_LATENCY(0), .TIMEOUT_CYCLES(TO_CYC)) dut0 (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wr[0]), .avm_readdata(rdata[0]),
        .id_value(idv[0]), .timestamp_value(tsv[0]),
        .busy(busy[0]), .done(done[0]), .id_match(match[0]), .timeout(tmo[0])
    );

    sysid_reader #(.EXPECTED_ID(EXP_ID), .READ_LATENCY(2), .TIMEOUT_CYCLES(TO_CYC)) dut2 (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wr[1]), .avm_readdata(rdata[1]),
        .id_value(idv[1]), .timestamp_value(tsv[1]),
        .busy(busy[1]), .done(done[1]), .id_match(match[1]), .timeout(tmo[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    // Responder: stalls each read for a programmed count, then returns the word
    // READ_LATENCY cycles after accept; every other cycle carries random junk.
    int          cyc = 0;
    int          stall_id [2] = '{0, 0};
    int          stall_ts [2] = '{0, 0};
    logic [31:0] word_id  [2] = '{32'h0, 32'h0};
    logic [31:0] word_ts  [2] = '{32'h0, 32'h0};
    int          wait_cnt [2] = '{0, 0};
    bit          pend_v   [2] = '{1'b0, 1'b0};
    int          pend_cyc [2] = '{0, 0};
    logic [31:0] pend_d   [2] = '{32'h0, 32'h0};
    logic [31:0] resp_w;

    always @(negedge clock) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            rdata[d] = $urandom;
            wr[d]    = 1'b0;
            if (reset) begin
                wait_cnt[d] = 0;
            end else if (rd[d]) begin
                if (wait_cnt[d] < (addr[d] ? stall_ts[d] : stall_id[d])) begin
                    wr[d]       = 1'b1;
                    wait_cnt[d] = wait_cnt[d] + 1;
                end else begin
                    wait_cnt[d] = 0;
                    resp_w      = addr[d] ? word_ts[d] : word_id[d];
                    if (lat_of(d) == 0) begin
                        rdata[d] = resp_w;
                    end else begin
                        pend_v[d]   = 1'b1;
                        pend_cyc[d] = cyc + lat_of(d);
                        pend_d[d]   = resp_w;
                    end
                end
            end
            if (pend_v[d] && pend_cyc[d] == cyc) begin
                rdata[d]  = pend_d[d];
                pend_v[d] = 1'b0;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: per-cycle {done,busy,read,addr} trace plus final register values.
    logic [3:0]  exp_tr   [2][$];
    int          exp_done [2];
    logic [31:0] m_id     [2] = '{32'h0, 32'h0};
    logic [31:0] m_ts     [2] = '{32'h0, 32'h0};
    bit          m_to     [2] = '{1'b0, 1'b0};
    bit          m_match  [2] = '{1'b0, 1'b0};

    task automatic model_seq(input int d, input int s_id, input int s_ts,
                             input logic [31:0] w_id, input logic [31:0] w_ts);
        int n;
        int st;
        int last;
        bit to;
        exp_tr[d].delete();
        exp_tr[d].push_back(4'b0000);
        to = 1'b0;
        for (int r = 0; r < 2; r++) begin
            if (!to) begin
                st   = (r == 0) ? s_id : s_ts;
                n    = st + 1 + lat_of(d);
                last = (TO_EN && n > TO_CYC) ? TO_CYC : n;
                for (int k = 1; k <= last; k++)
                    exp_tr[d].push_back({1'b0, 1'b1, (k <= st + 1), (r == 1)});
                if (TO_EN && n > TO_CYC) to = 1'b1;
                else if (r == 0)         m_id[d] = w_id;
                else                     m_ts[d] = w_ts;
            end
        end
        exp_tr[d].push_back(4'b1100);
        exp_done[d] = exp_tr[d].size() - 1;
        m_to[d]     = to;
        m_match[d]  = !to && (m_id[d] == EXP_ID);
        repeat (4) exp_tr[d].push_back(4'b0000);
    endtask

    function automatic bit tr_ok(input int d, input int k);
        logic [3:0] e;
        logic [3:0] a;
        e = exp_tr[d][k];
        a = {done[d], busy[d], rd[d], addr[d]};
        return (a[3:1] === e[3:1]) && (!e[1] || a[0] === e[0]);
    endfunction

    int got_done [2];

    // Runs one sequence starting at the current negedge (cycle 0); an optional
    // second start pulse lands while the DUTs are busy or in FINISH.
    task automatic run_seq(input string tag, input int s_id, input int s_ts,
                           input logic [31:0] w_id, input logic [31:0] w_ts, input int extra);
        int len;
        int lim_e;
        int tr_bad [2];
        bit match_at [2];
        bit tmo_at   [2];
        for (int d = 0; d < 2; d++) begin
            stall_id[d] = s_id;
            stall_ts[d] = s_ts;
            word_id[d]  = w_id;
            word_ts[d]  = w_ts;
            model_seq(d, s_id, s_ts, w_id, w_ts);
            tr_bad[d]   = 0;
            got_done[d] = -1;
            match_at[d] = 1'b0;
            tmo_at[d]   = 1'b0;
        end
        len   = (exp_tr[0].size() > exp_tr[1].size()) ? exp_tr[0].size() : exp_tr[1].size();
        lim_e = (exp_done[0] < exp_done[1]) ? exp_done[0] : exp_done[1];
        if (extra > lim_e) extra = lim_e;
        for (int d = 0; d < 2; d++)
            while (exp_tr[d].size() < len) exp_tr[d].push_back(4'b0000);
        for (int k = 0; k < len; k++) begin
            start = (k == 0) || (extra > 0 && k == extra);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (!tr_ok(d, k)) tr_bad[d] = tr_bad[d] + 1;
                if (done[d] && got_done[d] < 0) begin
                    got_done[d] = k;
                    match_at[d] = match[d];
                    tmo_at[d]   = tmo[d];
                end
            end
            @(negedge clock);
        end
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s trace_errs d%0d", tag, d), tr_bad[d], 0);
            check($sformatf("%s done_cycle d%0d", tag, d), got_done[d], exp_done[d]);
            check($sformatf("%s id_value d%0d", tag, d), idv[d], m_id[d]);
            check($sformatf("%s timestamp d%0d", tag, d), tsv[d], m_ts[d]);
            check($sformatf("%s id_match d%0d", tag, d), {31'b0, match_at[d]}, {31'b0, m_match[d]});
            check($sformatf("%s timeout d%0d", tag, d), {31'b0, tmo_at[d]}, {31'b0, m_to[d]});
        end
    endtask

    typedef struct {
        int          s_id;
        int          s_ts;
        logic [31:0] w_id;
        logic [31:0] w_ts;
        int          extra;
        int          done0;
        int          done2;
        logic        match0;
        logic        match2;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int          d_at  [2];
        bit          t_at  [2];
        int          post_bad [2];
        int          pre_bad  [2];
        logic [31:0] rid;

        tbl[0] = '{0, 0, 32'h1234_5678, 32'h0000_00A5, 0,  3,  7, 1'b1, 1'b1};
        tbl[1] = '{5, 5, EXP_ID,        32'hCAFE_0001, 0, 13, 17, 1'b1, 1'b1};
        tbl[2] = '{0, 0, 32'hDEAD_BEEF, 32'h5555_AAAA, 0,  3,  7, 1'b0, 1'b0};
        tbl[3] = '{2, 7, 32'h1234_5679, 32'h0BAD_F00D, 2, 12, 16, 1'b0, 1'b0};
        tbl[4] = '{0, 0, EXP_ID,        32'h0000_0001, 3,  3,  7, 1'b1, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset ctl d%0d", d), {27'b0, rd[d], busy[d], done[d], match[d], tmo[d]}, 32'h0);
            check($sformatf("reset id d%0d", d), idv[d], 32'h0);
            check($sformatf("reset ts d%0d", d), tsv[d], 32'h0);
        end
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_seq($sformatf("vec%0d", i), tbl[i].s_id, tbl[i].s_ts, tbl[i].w_id, tbl[i].w_ts, tbl[i].extra);
            check($sformatf("vec%0d table_done d0", i), got_done[0], tbl[i].done0);
            check($sformatf("vec%0d table_done d1", i), got_done[1], tbl[i].done2);
            check($sformatf("vec%0d table_match d0", i), {31'b0, match[0]}, {31'b0, tbl[i].match0});
            check($sformatf("vec%0d table_match d1", i), {31'b0, match[1]}, {31'b0, tbl[i].match2});
        end

        run_seq("edge", 13, 14, EXP_ID, 32'hE0E0_0001, 0);

        for (int i = 0; i < 20; i++) begin
            rid = $urandom_range(0, 1) ? EXP_ID : $urandom;
            run_seq($sformatf("rnd%0d", i), $urandom_range(0, 18), $urandom_range(0, 18),
                    rid, $urandom, $urandom_range(0, 40));
        end

        // Responder never releases waitrequest on the ID read.
        for (int d = 0; d < 2; d++) begin
            stall_id[d] = 100000;
            d_at[d]     = -1;
            t_at[d]     = 1'b0;
        end
        for (int k = 0; k <= 40; k++) begin
            start = (k == 0);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (done[d] && d_at[d] < 0) begin
                    d_at[d] = k;
                    t_at[d] = tmo[d];
                end
            end
            if (k < 40) @(negedge clock);
        end
        for (int d = 0; d < 2; d++) begin
`ifdef SYSID_READER_TIMEOUT_EN
            check($sformatf("stuck done_cycle d%0d", d), d_at[d], 1 + TO_CYC);
            check($sformatf("stuck timeout d%0d", d), {31'b0, t_at[d]}, 32'h1);
            check($sformatf("stuck id_match d%0d", d), {31'b0, match[d]}, 32'h0);
            check($sformatf("stuck id_kept d%0d", d), idv[d], m_id[d]);
`else
            check($sformatf("stuck no_done d%0d", d), d_at[d], -1);
            check($sformatf("stuck busy d%0d", d), {31'b0, busy[d]}, 32'h1);
            check($sformatf("stuck read d%0d", d), {31'b0, rd[d]}, 32'h1);
`endif
        end
        reset = 1'b1;
        @(negedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midread_reset read d%0d", d), {31'b0, rd[d]}, 32'h0);
            check($sformatf("midread_reset busy d%0d", d), {31'b0, busy[d]}, 32'h0);
            m_id[d] = '0;
            m_ts[d] = '0;
        end
        @(negedge clock);
        reset = 1'b0;

        // Reset lands while the latency-2 instance sits in LAT_TS; its late word must be dropped.
        for (int d = 0; d < 2; d++) begin
            model_seq(d, 0, 0, EXP_ID, 32'h7777_1111);
            stall_id[d] = 0;
            stall_ts[d] = 0;
            word_id[d]  = EXP_ID;
            word_ts[d]  = 32'h7777_1111;
            pre_bad[d]  = 0;
            post_bad[d] = 0;
        end
        for (int k = 0; k <= 10; k++) begin
            start = (k == 0) || (k == 2);
            reset = (k == 5);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (k <= 5 && !tr_ok(d, k)) pre_bad[d] = pre_bad[d] + 1;
                if (k >= 6 && ({rd[d], busy[d], done[d], match[d], tmo[d]} !== 5'b0 ||
                               idv[d] !== 32'h0 || tsv[d] !== 32'h0))
                    post_bad[d] = post_bad[d] + 1;
            end
            @(negedge clock);
        end
        start = 1'b0;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("lat_ts_reset pre_trace d%0d", d), pre_bad[d], 0);
            check($sformatf("lat_ts_reset post_state d%0d", d), post_bad[d], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
